key_tile_drawer: RTL and testbench



---
 rtl/key_tile_drawer_if.sv | 25 ++
 rtl/key_tile_drawer.sv | 125 ++++++++++++
 tb/tb_key_tile_drawer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/key_tile_drawer_if.sv
// Request/status and VGA pixel-write signals between the keypress logic, the tile drawer and the adapter.
// master = upstream requester/observer side, slave = the tile drawer itself.
interface key_tile_drawer_if;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic       start;
    logic [2:0] colour_in;
    logic       erase;
    logic       busy;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output x_in, y_in, start, colour_in, erase,
        input  busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  x_in, y_in, start, colour_in, erase,
        output busy, done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/key_tile_drawer.sv
// Rasterises a TILE_W x TILE_H tile, one registered pixel per clock, first plot 1 cycle after accept, done TILE_W*TILE_H+1 after.
// No backpressure or queueing: requests are ignored while busy/done; KEY_TILE_BORDER_EN paints the perimeter white.
module key_tile_drawer #(
    parameter int TILE_W = 4,
    parameter int TILE_H = 4,
    parameter int X_MAX  = 159,
    parameter int Y_MAX  = 119
) (
    input logic              clock,
    input logic              resetn,
    key_tile_drawer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t     state;
    logic       armed;
    logic       fin;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] col;
    logic [3:0] cx;
    logic [3:0] cy;

    logic [8:0] px;
    logic [7:0] py;
    logic       last_col;
    logic       last_row;
    logic       vis;
    logic [2:0] pix_col;

    // One spare bit on each sum so a tile hanging past 255/127 is clipped, not wrapped.
    assign px       = {1'b0, x0} + {5'd0, cx};
    assign py       = {1'b0, y0} + {4'd0, cy};
    assign last_col = (cx == 4'(TILE_W - 1));
    assign last_row = (cy == 4'(TILE_H - 1));
    assign vis      = (px <= 9'(X_MAX)) && (py <= 8'(Y_MAX));

`ifdef KEY_TILE_BORDER_EN
    logic erase_q;
    assign pix_col = (!erase_q && (cx == 4'd0 || last_col || cy == 4'd0 || last_row)) ? 3'b111 : col;
`else
    assign pix_col = col;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            armed          <= 1'b1;
            fin            <= 1'b0;
            x0             <= '0;
            y0             <= '0;
            col            <= '0;
            cx             <= '0;
            cy             <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot   <= 1'b0;
`ifdef KEY_TILE_BORDER_EN
            erase_q        <= 1'b0;
`endif
        end else begin
            // Re-arm only once start has been seen low, so a held request draws one tile.
            if (!bus.start) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start && armed) begin
                        armed <= 1'b0;
                        x0    <= bus.x_in;
                        y0    <= bus.y_in;
                        col   <= bus.erase ? 3'b000 : bus.colour_in;
                        cx    <= '0;
                        cy    <= '0;
                        fin   <= 1'b0;
                        state <= DRAW;
`ifdef KEY_TILE_BORDER_EN
                        erase_q <= bus.erase;
`endif
                    end
                end

                DRAW: begin
                    if (fin) begin
                        bus.busy     <= 1'b0;
                        bus.vga_plot <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end else begin
                        bus.busy       <= 1'b1;
                        bus.vga_x      <= px[7:0];
                        bus.vga_y      <= py[6:0];
                        bus.vga_colour <= pix_col;
                        bus.vga_plot   <= vis;
                        if (last_col) begin
                            cx <= '0;
                            if (last_row) begin
                                cy  <= '0;
                                fin <= 1'b1;
                            end else begin
                                cy <= cy + 4'd1;
                            end
                        end else begin
                            cx <= cx + 4'd1;
                        end
                    end
                end

                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_tile_drawer.sv
// Directed bench for key_tile_drawer: origin/clip/hold/reset-abort cases with hand-derived pixel lists.
module tb_key_tile_drawer;

    logic clock;
    logic resetn;
    int   total;
    int   passes;
    int   fails;
    int   np;
    int   nd;

    key_tile_drawer_if bus ();

    key_tile_drawer dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_col(input logic [2:0] c, input logic e, input int cx, input int cy);
        if (e) return 3'b000;
`ifdef KEY_TILE_BORDER_EN
        if (cx == 0 || cx == 3 || cy == 0 || cy == 3) return 3'b111;
`endif
        return c;
    endfunction

    // Called on a negedge with the block idle and armed; returns on a negedge with it idle again.
    task automatic tile(input string tag, input int x, input int y, input logic [2:0] c, input logic e);
        int px;
        int py;
        logic vis;
        bus.x_in      = 8'(x);
        bus.y_in      = 7'(y);
        bus.colour_in = c;
        bus.erase     = e;
        bus.start     = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        chk({tag, ".busy0"}, 32'(bus.busy), 32'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            px  = x + (k % 4);
            py  = y + (k / 4);
            vis = (px <= 159) && (py <= 119);
            chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
            chk({tag, ".plot"}, 32'(bus.vga_plot), 32'(vis));
            if (vis) begin
                chk({tag, ".x"}, 32'(bus.vga_x), 32'(px));
                chk({tag, ".y"}, 32'(bus.vga_y), 32'(py));
                chk({tag, ".col"}, 32'(bus.vga_colour), 32'(exp_col(c, e, k % 4, k / 4)));
            end
        end
        @(negedge clock);
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".busy17"}, 32'(bus.busy), 32'd0);
        chk({tag, ".plot17"}, 32'(bus.vga_plot), 32'd0);
        @(negedge clock);
        chk({tag, ".done18"}, 32'(bus.done), 32'd0);
    endtask

    task automatic window(input int n, output int plots, output int dones);
        plots = 0;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            plots += int'(bus.vga_plot);
            dones += int'(bus.done);
        end
    endtask

    initial begin
        total  = 0;
        passes = 0;
        fails  = 0;
        resetn        = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.colour_in = '0;
        bus.erase     = 1'b0;
        bus.start     = 1'b0;

        @(negedge clock);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.plot", 32'(bus.vga_plot), 32'd0);
        chk("rst.x", 32'(bus.vga_x), 32'd0);
        chk("rst.y", 32'(bus.vga_y), 32'd0);
        chk("rst.col", 32'(bus.vga_colour), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        tile("basic", 52, 30, 3'b100, 1'b0);

        // Held request: one tile only, then a one-cycle drop re-arms.
        bus.x_in      = 8'd10;
        bus.y_in      = 7'd20;
        bus.colour_in = 3'b001;
        bus.start     = 1'b1;
        window(60, np, nd);
        chk("hold.plots", 32'(np), 32'd16);
        chk("hold.dones", 32'(nd), 32'd1);
        bus.start = 1'b0;
        @(negedge clock);
        bus.start = 1'b1;
        window(30, np, nd);
        chk("rearm.plots", 32'(np), 32'd16);
        chk("rearm.dones", 32'(nd), 32'd1);
        bus.start = 1'b0;
        @(negedge clock);

        tile("edge", 158, 118, 3'b110, 1'b0);
        tile("ovf", 254, 126, 3'b111, 1'b0);

        // Mid-draw request is ignored, then reset aborts the tile.
        bus.x_in      = 8'd20;
        bus.y_in      = 7'd40;
        bus.colour_in = 3'b011;
        bus.erase     = 1'b0;
        bus.start     = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        bus.x_in  = 8'd100;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        chk("mid.x", 32'(bus.vga_x), 32'd22);
        chk("mid.y", 32'(bus.vga_y), 32'd41);
        @(negedge clock);
        chk("mid.plot8", 32'(bus.vga_plot), 32'd1);
        chk("mid.x8", 32'(bus.vga_x), 32'd23);
        #2 resetn = 1'b0;
        #1;
        chk("abort.plot", 32'(bus.vga_plot), 32'd0);
        chk("abort.busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        window(20, np, nd);
        chk("idle.plots", 32'(np), 32'd0);
        chk("idle.dones", 32'(nd), 32'd0);
        chk("idle.busy", 32'(bus.busy), 32'd0);

        tile("fresh", 0, 0, 3'b010, 1'b0);
        tile("erase", 0, 0, 3'b010, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
